usb_decoder: RTL and testbench
==============================

USB_DECODER -- requirements
Module: usb_decoder

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 8, meaning clk cycles per USB bit time (even, >=4).
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port d_plus  input  1  raw USB D+ line, asynchronous to clk.
REQ-005 SHALL have port d_minus  input  1  raw USB D- line, asynchronous to clk.
REQ-006 SHALL have port data_out  output  1  decoded, unstuffed bit; valid only with data_valid.
REQ-007 SHALL have port data_valid  output  1  one-cycle strobe per delivered bit.
REQ-008 SHALL have port rx_active  output  1  high from first K after idle until EOP complete.
REQ-009 SHALL have port eop  output  1  one-cycle strobe on end-of-packet.
REQ-010 SHALL have port stuff_err  output  1  one-cycle strobe on bit-stuff violation.

Function
REQ-011 SHALL pass d_plus/d_minus through a two-flop synchronizer; all logic uses synchronized lines only.
REQ-012 SHALL classify line state: J = (1,0), K = (0,1), SE0 = (0,0), SE1 = (1,1); SE1 treated as SE0.
REQ-013 SHALL run bit timer 0..CLKS_PER_BIT-1, wrapping, cleared to 0 on any synchronized line-state change.
REQ-014 SHALL sample line state when timer == CLKS_PER_BIT/2 (mid-bit).
REQ-015 SHALL NRZI-decode each J/K sample: 1 if equal to previous sampled J/K state, 0 if different; previous state initialises to J.
REQ-016 SHALL count consecutive decoded 1s (saturating at 7); after six 1s the next decoded bit is the stuff bit, discarded (no data_valid), count cleared.
REQ-017 SHALL assert stuff_err for one cycle, and clear the count, when the stuff bit decodes as 1.
REQ-018 SHALL assert data_valid with data_out one cycle after the sample strobe; pin-to-data_valid latency 2 + CLKS_PER_BIT/2 + 1 cycles.
REQ-019 SHALL implement FSM IDLE, RECEIVE, EOP_SE0, EOP_J.
REQ-020 IDLE: no output strobes; first sampled K -> RECEIVE, rx_active=1, that K decoded as bit 0.
REQ-021 RECEIVE: decode per REQ-015..018; sampled SE0 -> EOP_SE0, no data_valid for that sample.
REQ-022 EOP_SE0: second consecutive SE0 sample -> EOP_J; J or K sample -> RECEIVE without eop (glitch), sample not decoded.
REQ-023 EOP_J: J sample -> eop=1 one cycle, rx_active=0, previous state=J, counts cleared, -> IDLE; K sample -> IDLE with rx_active=0, no eop; further SE0 stays.
REQ-024 SHALL never assert data_valid and eop in the same cycle.

Reset
REQ-025 While rst high: FSM=IDLE, timer=0, ones count=0, previous state=J, synchronizer flops=J.
REQ-026 All outputs SHALL be 0 during and immediately after reset; reset mid-packet discards partial packet with no eop.

Configuration
REQ-027 With USB_DECODER_STUFF_CHECK_EN defined, stuff_err SHALL be driven per REQ-017.
REQ-028 Without it, stuff_err SHALL be tied 0; stuff bit still discarded regardless of value.

Structure
REQ-029 Shared package usb_pkg SHALL hold line-state enum (J, K, SE0), FSM state typedef, and constant STUFF_LIMIT=6.
REQ-030 Synchronizer and line-state classification SHALL be sub-module usb_rx_sync; timer, NRZI, unstuff and FSM in usb_decoder.

Verification
REQ-031 Reset asserted mid-packet -> all outputs 0 next cycle, rx_active stays 0 until next K.
REQ-032 Idle J then sync KJKJKJKK at 8 clk/bit -> data_valid x8, bits 0,0,0,0,0,0,0,1; rx_active rises.
REQ-033 After sync, six 1s (six equal states) then K-change stuff bit -> six data_valid with 1, no pulse for stuff bit, stuff_err=0.
REQ-034 After sync, seven 1s -> six data_valid, then stuff_err one cycle (macro on) / 0 (macro off), no seventh data_valid.
REQ-035 In packet: SE0, SE0, J -> eop one cycle, rx_active 0, no data_valid during EOP.
REQ-036 In packet: single SE0 bit then K -> no eop, rx_active stays 1, decoding resumes.

Source files
------------

// File: rtl/usb_pkg.sv
// ============================================================================
// Module      : usb_pkg
// Description : Shared types and constants for the USB receive decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package usb_pkg;

  typedef enum logic [1:0] {
    LS_J   = 2'd0,
    LS_K   = 2'd1,
    LS_SE0 = 2'd2
  } line_state_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECEIVE = 2'd1,
    ST_EOP_SE0 = 2'd2,
    ST_EOP_J   = 2'd3
  } rx_state_t;

  localparam int unsigned STUFF_LIMIT = 6;

  // SE1 is illegal on the bus and is folded into SE0.
  function automatic line_state_t classify_line(input logic dp, input logic dm);
    case ({dp, dm})
      2'b10:   return LS_J;
      2'b01:   return LS_K;
      default: return LS_SE0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/usb_rx_sync.sv
// ============================================================================
// Module      : usb_rx_sync
// Description : Two-flop synchronizer for D+/D- and line-state classification.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_rx_sync
  import usb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        d_plus,
  input  logic        d_minus,
  output line_state_t line_state,
  output logic        line_change
);

  logic        r_dp_meta;
  logic        r_dm_meta;
  logic        r_dp_sync;
  logic        r_dm_sync;
  line_state_t w_meta_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dp_meta <= 1'b1;
      r_dm_meta <= 1'b0;
      r_dp_sync <= 1'b1;
      r_dm_sync <= 1'b0;
    end else begin
      r_dp_meta <= d_plus;
      r_dm_meta <= d_minus;
      r_dp_sync <= r_dp_meta;
      r_dm_sync <= r_dm_meta;
    end
  end

  assign w_meta_state = classify_line(r_dp_meta, r_dm_meta);
  assign line_state   = classify_line(r_dp_sync, r_dm_sync);

  // Flags a state change one cycle early so the bit timer clears on the same
  // edge that the new synchronized state appears.
  assign line_change  = (w_meta_state != line_state);

endmodule

`default_nettype wire

// File: rtl/usb_decoder.sv
// ============================================================================
// Module      : usb_decoder
// Description : USB full/low-speed receive path: bit timing, NRZI decode,
//               bit unstuffing and packet framing (SOP/EOP).
//               Optional: USB_DECODER_STUFF_CHECK_EN drives stuff_err.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_decoder
  import usb_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic d_plus,
  input  logic d_minus,
  output logic data_out,
  output logic data_valid,
  output logic rx_active,
  output logic eop,
  output logic stuff_err
);

  localparam int              c_TW          = $clog2(CLKS_PER_BIT);
  localparam logic [c_TW-1:0] c_HALF_BIT    = c_TW'(CLKS_PER_BIT / 2);
  localparam logic [c_TW-1:0] c_LAST_TICK   = c_TW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      c_STUFF_LIMIT = 3'(STUFF_LIMIT);
  localparam logic [2:0]      c_ONES_MAX    = 3'd7;

  line_state_t     w_line;
  logic            w_line_change;
  logic [c_TW-1:0] r_timer;
  logic            w_sample;
  logic            w_bit;

  rx_state_t       r_state;
  rx_state_t       w_state_nxt;
  line_state_t     r_prev;
  line_state_t     w_prev_nxt;
  logic [2:0]      r_ones;
  logic [2:0]      w_ones_nxt;
  logic            w_dv_nxt;
  logic            w_dout_nxt;
  logic            w_eop_nxt;
  logic            r_data_out;
  logic            r_data_valid;
  logic            r_eop;
  logic            r_rx_active;
`ifdef USB_DECODER_STUFF_CHECK_EN
  logic            w_serr_nxt;
  logic            r_stuff_err;
`endif

  usb_rx_sync u_rx_sync (
    .clk         (clk),
    .rst         (rst),
    .d_plus      (d_plus),
    .d_minus     (d_minus),
    .line_state  (w_line),
    .line_change (w_line_change)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer <= '0;
    end else if (w_line_change || (r_timer == c_LAST_TICK)) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + 1'b1;
    end
  end

  assign w_sample = (r_timer == c_HALF_BIT);
  assign w_bit    = (w_line == r_prev);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_prev_nxt  = r_prev;
    w_ones_nxt  = r_ones;
    w_dv_nxt    = 1'b0;
    w_dout_nxt  = 1'b0;
    w_eop_nxt   = 1'b0;
`ifdef USB_DECODER_STUFF_CHECK_EN
    w_serr_nxt  = 1'b0;
`endif
    if (w_sample) begin
      case (r_state)
        ST_IDLE: begin
          // The first K of the sync pattern is always a 0 against idle J.
          if (w_line == LS_K) begin
            w_state_nxt = ST_RECEIVE;
            w_dv_nxt    = 1'b1;
            w_dout_nxt  = 1'b0;
            w_prev_nxt  = LS_K;
            w_ones_nxt  = '0;
          end
        end
        ST_RECEIVE: begin
          if (w_line == LS_SE0) begin
            w_state_nxt = ST_EOP_SE0;
          end else begin
            w_prev_nxt = w_line;
            if (r_ones >= c_STUFF_LIMIT) begin
              w_ones_nxt = '0;
`ifdef USB_DECODER_STUFF_CHECK_EN
              w_serr_nxt = w_bit;
`endif
            end else begin
              w_dv_nxt   = 1'b1;
              w_dout_nxt = w_bit;
              if (!w_bit) begin
                w_ones_nxt = '0;
              end else if (r_ones != c_ONES_MAX) begin
                w_ones_nxt = r_ones + 3'd1;
              end
            end
          end
        end
        ST_EOP_SE0: begin
          // A lone SE0 bit is a glitch; the recovering sample is dropped.
          if (w_line == LS_SE0) begin
            w_state_nxt = ST_EOP_J;
          end else begin
            w_state_nxt = ST_RECEIVE;
          end
        end
        ST_EOP_J: begin
          if (w_line != LS_SE0) begin
            w_state_nxt = ST_IDLE;
            w_prev_nxt  = LS_J;
            w_ones_nxt  = '0;
            w_eop_nxt   = (w_line == LS_J);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev       <= LS_J;
      r_ones       <= '0;
      r_data_out   <= 1'b0;
      r_data_valid <= 1'b0;
      r_eop        <= 1'b0;
      r_rx_active  <= 1'b0;
    end else begin
      r_prev       <= w_prev_nxt;
      r_ones       <= w_ones_nxt;
      r_data_out   <= w_dout_nxt;
      r_data_valid <= w_dv_nxt;
      r_eop        <= w_eop_nxt;
      r_rx_active  <= (w_state_nxt != ST_IDLE);
    end
  end

`ifdef USB_DECODER_STUFF_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stuff_err <= 1'b0;
    end else begin
      r_stuff_err <= w_serr_nxt;
    end
  end

  assign stuff_err = r_stuff_err;
`else
  assign stuff_err = 1'b0;
`endif

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign eop        = r_eop;
  assign rx_active  = r_rx_active;

endmodule

`default_nettype wire

// File: tb/tb_usb_decoder.sv
// ============================================================================
// Module      : tb_usb_decoder
// Description : Directed self-checking bench for usb_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_usb_decoder;

  localparam int         CPB = 8;
  localparam logic [1:0] LJ  = 2'b10;
  localparam logic [1:0] LK  = 2'b01;
  localparam logic [1:0] LSE = 2'b00;

  logic tb_clk  = 1'b0;
  logic rst     = 1'b1;
  logic d_plus  = 1'b1;
  logic d_minus = 1'b0;
  logic data_out, data_valid, rx_active, eop, stuff_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic q[$];
  int   eop_cnt  = 0;
  int   serr_cnt = 0;
  int   both_cnt = 0;

  always #5 tb_clk = ~tb_clk;

  usb_decoder #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (tb_clk),
    .rst        (rst),
    .d_plus     (d_plus),
    .d_minus    (d_minus),
    .data_out   (data_out),
    .data_valid (data_valid),
    .rx_active  (rx_active),
    .eop        (eop),
    .stuff_err  (stuff_err)
  );

  always @(negedge tb_clk) begin
    if (data_valid) q.push_back(data_out);
    if (eop) eop_cnt++;
    if (stuff_err) serr_cnt++;
    if (data_valid && eop) both_cnt++;
  end

  task automatic drive(input logic [1:0] ls, input int nbits);
    {d_plus, d_minus} = ls;
    repeat (nbits * CPB) @(negedge tb_clk);
  endtask

  task automatic send_sync;
    drive(LK, 1); drive(LJ, 1); drive(LK, 1); drive(LJ, 1);
    drive(LK, 1); drive(LJ, 1); drive(LK, 2);
  endtask

  task automatic send_eop;
    drive(LSE, 2);
    drive(LJ, 3);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge tb_clk);
    n_cmp++;
    if ({data_out, data_valid, rx_active, eop, stuff_err} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b expected 00000",
               {data_out, data_valid, rx_active, eop, stuff_err});
    end
    rst = 1'b0;
    drive(LJ, 3);
    n_cmp++;
    if (rx_active !== 1'b0 || q.size() != 0) begin
      n_bad++;
      $display("FAIL reset_idle: rx_active %b bits %0d expected 0/0", rx_active, q.size());
    end
  endtask

  task automatic test_sync;
    int q0, e0, b0;
    logic [31:0] e;
    logic got;
    drive(LJ, 2);
    q0 = q.size(); e0 = eop_cnt; b0 = both_cnt;
    send_sync;
    n_cmp++;
    if (rx_active !== 1'b1) begin
      n_bad++;
      $display("FAIL sync_rx_active: got %b expected 1", rx_active);
    end
    e = 32'b0000_0001;
    n_cmp++;
    if (q.size() != q0 + 8) begin
      n_bad++;
      $display("FAIL sync_count: got %0d expected 8", q.size() - q0);
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      got = (q0 + i < q.size()) ? q[q0 + i] : 1'bx;
      if (got !== e[7 - i]) begin
        n_bad++;
        $display("FAIL sync_bit%0d: got %b expected %b", i, got, e[7 - i]);
      end
    end
    send_eop;
    n_cmp++;
    if (eop_cnt - e0 != 1) begin
      n_bad++;
      $display("FAIL eop_pulses: got %0d expected 1", eop_cnt - e0);
    end
    n_cmp++;
    if (rx_active !== 1'b0) begin
      n_bad++;
      $display("FAIL eop_rx_active: got %b expected 0", rx_active);
    end
    n_cmp++;
    if (q.size() != q0 + 8 || both_cnt != b0) begin
      n_bad++;
      $display("FAIL eop_no_data: bits %0d overlap %0d expected 8/0", q.size() - q0, both_cnt - b0);
    end
  endtask

  task automatic test_stuff_ok;
    int q0, s0;
    logic [31:0] e;
    logic got;
    drive(LJ, 2);
    q0 = q.size(); s0 = serr_cnt;
    send_sync;
    drive(LJ, 7);
    drive(LK, 1);
    drive(LJ, 1);
    send_eop;
    e = 32'b0000_0001_0111_1110;
    n_cmp++;
    if (q.size() != q0 + 16) begin
      n_bad++;
      $display("FAIL stuff_ok_count: got %0d expected 16", q.size() - q0);
    end
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      got = (q0 + i < q.size()) ? q[q0 + i] : 1'bx;
      if (got !== e[15 - i]) begin
        n_bad++;
        $display("FAIL stuff_ok_bit%0d: got %b expected %b", i, got, e[15 - i]);
      end
    end
    n_cmp++;
    if (serr_cnt != s0) begin
      n_bad++;
      $display("FAIL stuff_ok_err: got %0d expected 0", serr_cnt - s0);
    end
  endtask

  task automatic test_stuff_err;
    int q0, s0, exp_err;
    logic [31:0] e;
    logic got;
`ifdef USB_DECODER_STUFF_CHECK_EN
    exp_err = 1;
`else
    exp_err = 0;
`endif
    drive(LJ, 2);
    q0 = q.size(); s0 = serr_cnt;
    send_sync;
    drive(LJ, 8);
    drive(LK, 1);
    send_eop;
    e = 32'b0000_0001_0111_1110;
    n_cmp++;
    if (q.size() != q0 + 16) begin
      n_bad++;
      $display("FAIL stuff_err_count: got %0d expected 16", q.size() - q0);
    end
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      got = (q0 + i < q.size()) ? q[q0 + i] : 1'bx;
      if (got !== e[15 - i]) begin
        n_bad++;
        $display("FAIL stuff_err_bit%0d: got %b expected %b", i, got, e[15 - i]);
      end
    end
    n_cmp++;
    if (serr_cnt - s0 != exp_err) begin
      n_bad++;
      $display("FAIL stuff_err_pulses: got %0d expected %0d", serr_cnt - s0, exp_err);
    end
  endtask

  task automatic test_glitch;
    int q0, e0;
    logic [31:0] e;
    logic got;
    drive(LJ, 2);
    q0 = q.size(); e0 = eop_cnt;
    send_sync;
    drive(LJ, 1);
    drive(LSE, 1);
    drive(LK, 1);
    n_cmp++;
    if (rx_active !== 1'b1 || eop_cnt != e0) begin
      n_bad++;
      $display("FAIL glitch_active: rx_active %b eop %0d expected 1/0", rx_active, eop_cnt - e0);
    end
    drive(LK, 2);
    send_eop;
    e = 32'b000_0000_1001;
    n_cmp++;
    if (q.size() != q0 + 11) begin
      n_bad++;
      $display("FAIL glitch_count: got %0d expected 11", q.size() - q0);
    end
    for (int i = 0; i < 11; i++) begin
      n_cmp++;
      got = (q0 + i < q.size()) ? q[q0 + i] : 1'bx;
      if (got !== e[10 - i]) begin
        n_bad++;
        $display("FAIL glitch_bit%0d: got %b expected %b", i, got, e[10 - i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    int q0, e0;
    logic got;
    drive(LJ, 2);
    q0 = q.size(); e0 = eop_cnt;
    drive(LK, 1); drive(LJ, 1); drive(LK, 1); drive(LJ, 1);
    drive(LK, 1);
    rst = 1'b1;
    {d_plus, d_minus} = LJ;
    #1;
    n_cmp++;
    if ({data_out, data_valid, rx_active, eop, stuff_err} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_mid_outputs: got %b expected 00000",
               {data_out, data_valid, rx_active, eop, stuff_err});
    end
    @(negedge tb_clk);
    rst = 1'b0;
    drive(LJ, 3);
    n_cmp++;
    if (rx_active !== 1'b0 || q.size() != q0 + 5 || eop_cnt != e0) begin
      n_bad++;
      $display("FAIL reset_mid_quiet: rx_active %b bits %0d eop %0d expected 0/5/0",
               rx_active, q.size() - q0, eop_cnt - e0);
    end
    drive(LK, 1);
    n_cmp++;
    if (rx_active !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid_restart: rx_active %b expected 1", rx_active);
    end
    n_cmp++;
    got = (q0 + 5 < q.size()) ? q[q0 + 5] : 1'bx;
    if (got !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_first_bit: got %b expected 0", got);
    end
    drive(LJ, 1);
    send_eop;
  endtask

  initial begin
    test_reset;
    test_sync;
    test_stuff_ok;
    test_stuff_err;
    test_glitch;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
